// File: rtl/segctl_pkg.sv
// segctl shared definitions: register word indices, CTRL bit
// positions, 7-segment cathode table and a byte-strobe helper.
package segctl_pkg;

  localparam logic [29:0] REG_CTRL  = 30'd0;
  localparam logic [29:0] REG_DATA  = 30'd1;
  localparam logic [29:0] REG_DP    = 30'd2;
  localparam logic [29:0] REG_LED   = 30'd3;
  localparam logic [29:0] REG_BLINK = 30'd4;

  localparam int CTRL_EN = 0;

  localparam logic [31:0] RD_UNMAPPED = 32'h5555_5555;

  // {dp,g,f,e,d,c,b,a}, active-low, dp off
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [31:0] byte_mask(
    input logic [3:0] strb
  );
    return {{8{strb[3]}}, {8{strb[2]}},
            {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/segctl_if.sv
// AXI4-Lite bundle for segctl.
// slave: register block side, master: bus/bench side.
interface segctl_if;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport slave (
    input  arvalid, araddr, arprot, rready,
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp,
    output awready, wready, bvalid, bresp
  );

  modport master (
    output arvalid, araddr, arprot, rready,
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp,
    input  awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/segctl_seg7_decode.sv
// Hex nibble + dp to active-low cathodes, combinational.
// Ports: nib (4), dp (1, 1 = lit), cat (8, {dp,g..a}).
module seg7_decode
  import segctl_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] cat
);

  logic [7:0] pat;

  assign pat = SEG_LUT[nib];
  assign cat = {pat[7] & ~dp, pat[6:0]};

endmodule

// File: rtl/segctl.sv
// 8-digit 7-segment scanner + LED register, AXI4-Lite slave.
// Ports: aclk, aresetn (sync, low), s_axi, seg_an, seg_cat, led.
// Optional macro SEGCTL_BLINK_EN adds the BLINK register.
module segctl
  import segctl_pkg::*;
#(
  parameter int unsigned SCAN_PERIOD  = 100000,
  parameter int unsigned BLINK_PERIOD = 25000000
) (
  input  logic       aclk,
  input  logic       aresetn,
  segctl_if.slave    s_axi,
  output logic [7:0] seg_an,
  output logic [7:0] seg_cat,
  output logic [15:0] led
);

  localparam int SW = $clog2(SCAN_PERIOD + 1);

  logic        ctrl_en;
  logic [31:0] data_q;
  logic [7:0]  dp_q;
  logic [15:0] led_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic [29:0] ar_idx;
  logic [29:0] aw_idx;
  logic        rd_go;
  logic        wr_go;
  logic [31:0] wmask;
  logic [31:0] wd;
  logic [31:0] rd_mux;
  logic [SW-1:0] scan_cnt;
  logic [2:0]  dig;
  logic [7:0]  dec_cat;
  logic        blank;

  assign ar_idx = s_axi.araddr[31:2];
  assign aw_idx = s_axi.awaddr[31:2];
  assign wd     = s_axi.wdata;
  assign wmask  = byte_mask(s_axi.wstrb);

  assign rd_go = s_axi.arvalid && !rvalid_q;
  assign wr_go = s_axi.awvalid && s_axi.wvalid
              && !bvalid_q;

  assign s_axi.arready = !rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.awready = wr_go;
  assign s_axi.wready  = wr_go;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.arprot, s_axi.awprot,
                       s_axi.araddr[1:0],
                       s_axi.awaddr[1:0]};

`ifdef SEGCTL_BLINK_EN
  localparam int BW = $clog2(BLINK_PERIOD + 1);

  logic [7:0]    blink_q;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  // phase only advances while enabled; it holds otherwise
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (ctrl_en) begin
      if (blink_cnt == BW'(BLINK_PERIOD - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign blank = phase && blink_q[dig];
`else
  localparam int unsigned UNUSED_BLINK = BLINK_PERIOD;
  assign blank = 1'b0;
`endif

  // reads sample registers before any same-cycle write
  always_comb begin
    rd_mux = RD_UNMAPPED;
    unique case (1'b1)
      ar_idx == REG_CTRL: rd_mux = {31'd0, ctrl_en};
      ar_idx == REG_DATA: rd_mux = data_q;
      ar_idx == REG_DP:   rd_mux = {24'd0, dp_q};
      ar_idx == REG_LED:  rd_mux = {16'd0, led_q};
`ifdef SEGCTL_BLINK_EN
      ar_idx == REG_BLINK: rd_mux = {24'd0, blink_q};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else if (rd_go) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
      rresp_q  <= 2'b00;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
    end else if (wr_go) begin
      bvalid_q <= 1'b1;
      bresp_q  <= 2'b00;
    end else if (bvalid_q && s_axi.bready) begin
      bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ctrl_en <= 1'b0;
      data_q  <= '0;
      dp_q    <= '0;
      led_q   <= '0;
`ifdef SEGCTL_BLINK_EN
      blink_q <= '0;
`endif
    end else if (wr_go) begin
      unique case (1'b1)
        aw_idx == REG_CTRL:
          ctrl_en <= (ctrl_en & ~wmask[CTRL_EN])
                   | (wd[CTRL_EN] & wmask[CTRL_EN]);
        aw_idx == REG_DATA:
          data_q <= (data_q & ~wmask) | (wd & wmask);
        aw_idx == REG_DP:
          dp_q <= (dp_q & ~wmask[7:0])
                | (wd[7:0] & wmask[7:0]);
        aw_idx == REG_LED:
          led_q <= (led_q & ~wmask[15:0])
                 | (wd[15:0] & wmask[15:0]);
`ifdef SEGCTL_BLINK_EN
        aw_idx == REG_BLINK:
          blink_q <= (blink_q & ~wmask[7:0])
                   | (wd[7:0] & wmask[7:0]);
`endif
        default: ;
      endcase
    end
  end

  // disabled: parked on digit 0 so enable starts a full dwell
  always_ff @(posedge aclk) begin
    if (!aresetn || !ctrl_en) begin
      scan_cnt <= '0;
      dig      <= '0;
    end else if (scan_cnt == SW'(SCAN_PERIOD - 1)) begin
      scan_cnt <= '0;
      dig      <= dig + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  seg7_decode u_dec (
    .nib (data_q[{dig, 2'b00} +: 4]),
    .dp  (dp_q[dig]),
    .cat (dec_cat)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn || !ctrl_en) begin
      seg_an  <= 8'hFF;
      seg_cat <= 8'hFF;
    end else begin
      seg_an  <= ~(8'd1 << dig);
      seg_cat <= blank ? 8'hFF : dec_cat;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_segctl.sv
// Directed bench for segctl, SCAN_PERIOD=4, BLINK_PERIOD=16.
// Covers the BLINK register when SEGCTL_BLINK_EN is defined.
module tb_segctl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;
  logic [15:0] led;
  logic [31:0] rv;
  int          checks = 0;
  int          errors = 0;

  logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB,
    8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] cat_tab [8] = '{8'hC0, 8'hF9, 8'hA4,
    8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  always #5 aclk = ~aclk;

  segctl_if s_axi ();

  segctl #(
    .SCAN_PERIOD  (4),
    .BLINK_PERIOD (16)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (s_axi),
    .seg_an  (seg_an),
    .seg_cat (seg_cat),
    .led     (led)
  );

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic wr_req(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] st);
    int n = 0;
    s_axi.awaddr  = a;
    s_axi.wdata   = d;
    s_axi.wstrb   = st;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    #1;
    while (!s_axi.awready && n < 20) begin
      tick(1);
      n++;
    end
    chk("aw_wait", n < 20);
    chk("wready", s_axi.wready === 1'b1);
    @(posedge aclk);
    #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    chk("bvalid_up", s_axi.bvalid === 1'b1);
    chk("bresp", s_axi.bresp === 2'b00);
  endtask

  task automatic wr_ack();
    s_axi.bready = 1'b1;
    @(posedge aclk);
    #1;
    s_axi.bready = 1'b0;
    chk("bvalid_dn", s_axi.bvalid === 1'b0);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] st);
    wr_req(a, d, st);
    wr_ack();
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d);
    int n = 0;
    s_axi.araddr  = a;
    s_axi.arvalid = 1'b1;
    #1;
    while (!s_axi.arready && n < 20) begin
      tick(1);
      n++;
    end
    chk("ar_wait", n < 20);
    @(posedge aclk);
    #1;
    s_axi.arvalid = 1'b0;
    chk("rvalid_up", s_axi.rvalid === 1'b1);
    chk("rresp", s_axi.rresp === 2'b00);
    d = s_axi.rdata;
    s_axi.rready = 1'b1;
    @(posedge aclk);
    #1;
    s_axi.rready = 1'b0;
    chk("rvalid_dn", s_axi.rvalid === 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axi.arvalid = 1'b0;
    s_axi.araddr  = '0;
    s_axi.arprot  = '0;
    s_axi.rready  = 1'b0;
    s_axi.awvalid = 1'b0;
    s_axi.awaddr  = '0;
    s_axi.awprot  = 3'b111;
    s_axi.wvalid  = 1'b0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.bready  = 1'b0;
    tick(3);
    chk("rst_an", seg_an === 8'hFF);
    chk("rst_cat", seg_cat === 8'hFF);
    chk("rst_led", led === 16'h0000);
    chk("rst_rvalid", s_axi.rvalid === 1'b0);
    chk("rst_bvalid", s_axi.bvalid === 1'b0);
    chk("rst_arready", s_axi.arready === 1'b1);
    chk("rst_awready", s_axi.awready === 1'b0);
    aresetn = 1'b1;
    tick(1);
    rd(32'h4, rv);
    chk("rst_data", rv === 32'h0);

    wr(32'h4, 32'h7654_3210, 4'hF);
    wr(32'h0, 32'h1, 4'hF);
    for (int d = 0; d < 9; d++) begin
      chk("scan_an", seg_an === an_tab[d % 8]);
      chk("scan_cat", seg_cat === cat_tab[d % 8]);
      tick(3);
      chk("dwell_an", seg_an === an_tab[d % 8]);
      tick(1);
    end

    wr(32'h0, 32'h0, 4'hF);
    chk("dis_an", seg_an === 8'hFF);
    chk("dis_cat", seg_cat === 8'hFF);

    wr(32'h4, 32'hFFFF_FFFF, 4'b0100);
    rd(32'h4, rv);
    chk("strb_data", rv === 32'h76FF_3210);
    wr(32'h8, 32'h01, 4'b0001);
    wr(32'h8, 32'h00, 4'b0000);
    rd(32'h8, rv);
    chk("dp_strb", rv === 32'h1);
    wr(32'h8, 32'hFFFF_FF01, 4'hF);
    rd(32'h8, rv);
    chk("dp_unused", rv === 32'h1);

    wr(32'h0, 32'h1, 4'hF);
    chk("dp_an0", seg_an === 8'hFE);
    chk("dp_cat0", seg_cat === 8'h40);
    tick(4);
    chk("dp_an1", seg_an === 8'hFD);
    chk("dp_cat1", seg_cat === 8'hF9);
    tick(12);
    chk("hexf_an", seg_an === 8'hEF);
    chk("hexf_cat", seg_cat === 8'h8E);

    s_axi.araddr  = 32'h1C;
    s_axi.arvalid = 1'b1;
    #1;
    chk("um_arready", s_axi.arready === 1'b1);
    tick(1);
    s_axi.arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("um_rvalid", s_axi.rvalid === 1'b1);
      chk("um_rdata", s_axi.rdata === 32'h5555_5555);
      chk("um_rresp", s_axi.rresp === 2'b00);
      chk("um_arready0", s_axi.arready === 1'b0);
      tick(1);
    end
    s_axi.rready = 1'b1;
    tick(1);
    s_axi.rready = 1'b0;
    chk("um_rdone", s_axi.rvalid === 1'b0);

    wr(32'h24, 32'hDEAD_BEEF, 4'hF);
    rd(32'h4, rv);
    chk("um_wr_drop", rv === 32'h76FF_3210);

    wr(32'hC, 32'hFFFF_FFFF, 4'hF);
    rd(32'hC, rv);
    chk("led_unused", rv === 32'h0000_FFFF);
    chk("led_ffff", led === 16'hFFFF);

    s_axi.araddr  = 32'hC;
    s_axi.awaddr  = 32'hC;
    s_axi.wdata   = 32'h0000_A5A5;
    s_axi.wstrb   = 4'hF;
    s_axi.arvalid = 1'b1;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    #1;
    chk("rw_arready", s_axi.arready === 1'b1);
    chk("rw_awready", s_axi.awready === 1'b1);
    tick(1);
    s_axi.arvalid = 1'b0;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    chk("rw_rvalid", s_axi.rvalid === 1'b1);
    chk("rw_old", s_axi.rdata === 32'h0000_FFFF);
    chk("led_a5a5", led === 16'hA5A5);
    chk("rw_bvalid", s_axi.bvalid === 1'b1);
    s_axi.rready = 1'b1;
    s_axi.bready = 1'b1;
    tick(1);
    s_axi.rready = 1'b0;
    s_axi.bready = 1'b0;
    chk("rw_rdone", s_axi.rvalid === 1'b0);
    chk("rw_bdone", s_axi.bvalid === 1'b0);

    wr_req(32'h4, 32'h1111_1111, 4'hF);
    aresetn = 1'b0;
    tick(1);
    chk("mid_bvalid", s_axi.bvalid === 1'b0);
    chk("mid_an", seg_an === 8'hFF);
    chk("mid_cat", seg_cat === 8'hFF);
    chk("mid_led", led === 16'h0000);
    aresetn = 1'b1;
    tick(1);
    chk("post_bvalid", s_axi.bvalid === 1'b0);
    rd(32'h4, rv);
    chk("post_data", rv === 32'h0);
    rd(32'h0, rv);
    chk("post_ctrl", rv === 32'h0);

`ifdef SEGCTL_BLINK_EN
    wr(32'h4, 32'h7654_3210, 4'hF);
    wr(32'h10, 32'h02, 4'hF);
    rd(32'h10, rv);
    chk("blink_rd", rv === 32'h2);
    wr(32'h0, 32'h1, 4'hF);
    tick(14);
    wr(32'h0, 32'h0, 4'hF);
    wr(32'h0, 32'h1, 4'hF);
    chk("bl_an0", seg_an === 8'hFE);
    chk("bl_cat0", seg_cat === 8'hC0);
    tick(4);
    chk("bl_an1", seg_an === 8'hFD);
    chk("bl_cat1", seg_cat === 8'hFF);
    tick(3);
    chk("bl_cat1b", seg_cat === 8'hFF);
    tick(1);
    chk("bl_an2", seg_an === 8'hFB);
    chk("bl_cat2", seg_cat === 8'hA4);
    tick(8);
    chk("bl_an4", seg_an === 8'hEF);
    chk("bl_cat4", seg_cat === 8'h99);
    tick(16);
    chk("bl_an0r", seg_an === 8'hFE);
    chk("bl_cat0r", seg_cat === 8'hC0);
    tick(4);
    chk("bl_an1r", seg_an === 8'hFD);
    chk("bl_cat1r", seg_cat === 8'hFF);
`else
    rd(32'h10, rv);
    chk("nobl_rd", rv === 32'h5555_5555);
    wr(32'h10, 32'h02, 4'hF);
    rd(32'h10, rv);
    chk("nobl_rd2", rv === 32'h5555_5555);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
